// File: rtl/pim_pkg.sv
// Shared types and sizing helpers for the PIM port arbiter.
// Imported by the arbiter interface, the round-robin picker and the top.
package pim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  // The wait counter runs from lat-1 down to 0, so it never needs to hold lat itself.
  function automatic int lat_cnt_w(input int lat);
    return (lat <= 1) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/pim_arbiter_if.sv
// Requester-side bundle of the PIM arbiter: requests, write payload, grants and completions.
// master = requester side, slave = arbiter side.
interface pim_arbiter_if
  import pim_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW
);

  logic [NUM_REQ-1:0]    i_req;
  logic [NUM_REQ-1:0]    i_we;
  logic [NUM_REQ*AW-1:0] i_addr;
  logic [NUM_REQ*DW-1:0] i_wdata;
  logic [NUM_REQ-1:0]    o_gnt;
  logic [NUM_REQ-1:0]    o_rvalid;
  logic [DW-1:0]         o_rdata;

  modport master (
    output i_req, i_we, i_addr, i_wdata,
    input  o_gnt, o_rvalid, o_rdata
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata,
    output o_gnt, o_rvalid, o_rdata
  );

endinterface

// File: rtl/pim_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping mod NUM_REQ.
// Zero latency; no state, the caller owns the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IW-1:0]      gnt_idx_o
);

  logic          found;
  logic [IW:0]   pos;
  logic [IW-1:0] sel;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    pos       = '0;
    sel       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr_i} + (IW+1)'(i);
      if (pos >= (IW+1)'(NUM_REQ)) begin
        pos = pos - (IW+1)'(NUM_REQ);
      end
      sel = pos[IW-1:0];
      if (!found && req_i[sel]) begin
        found         = 1'b1;
        gnt_oh_o[sel] = 1'b1;
        gnt_idx_o     = sel;
      end
    end
  end

endmodule

// File: rtl/pim_arbiter.sv
// Shares one PIM macro port among NUM_REQ requesters, one transaction at a time, round-robin.
// Grant at T; write completes at T+1, read at T+RD_LAT+1; requests wait (held) while busy.
module pim_arbiter
  import pim_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int RD_LAT  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  pim_arbiter_if.slave      req_if,
  output logic              o_busy,
  output logic              o_pim_en,
  output logic              o_pim_we,
  output logic [AW-1:0]     o_pim_addr,
  output logic [DW-1:0]     o_pim_wd,
  input  logic [DW-1:0]     i_pim_rd
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = lat_cnt_w(RD_LAT);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NUM_REQ-1:0] win_oh;
  logic [IW-1:0]      win_idx;
  logic               win_vld;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req_i     (req_if.i_req),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (win_oh),
    .gnt_idx_o (win_idx)
  );

  assign win_vld = |win_oh;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          owner_d = win_idx;
          for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == IW'(k)) begin
              we_d   = req_if.i_we[k];
              addr_d = req_if.i_addr[k*AW +: AW];
              wd_d   = req_if.i_wdata[k*DW +: DW];
            end
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ptr_d   = (owner_q == IW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
        cnt_d   = CW'(RD_LAT-1);
        state_d = we_q ? RESP : WAIT;
      end
      WAIT: begin
        // Address is still held on the macro, so the last wait cycle sees valid read data.
        if (cnt_q == '0) begin
          rdata_d = i_pim_rd;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_if.o_gnt    = (state_q == ISSUE) ? (NUM_REQ'(1) << owner_q) : '0;
  assign req_if.o_rvalid = (state_q == RESP)  ? (NUM_REQ'(1) << owner_q) : '0;
  assign req_if.o_rdata  = (state_q == RESP && !we_q) ? rdata_q : '0;

  assign o_busy     = (state_q != IDLE);
  assign o_pim_en   = (state_q == ISSUE);
  assign o_pim_we   = (state_q == ISSUE) && we_q;
  // Address and write data stay parked between accesses to keep the macro pins quiet.
  assign o_pim_addr = addr_q;
  assign o_pim_wd   = wd_q;

endmodule
